// File: rtl/fft_ser_pkg.sv
// fft_ser_pkg
// Shared definitions for the FFT result serializer:
//   - state_t     : serializer FSM state encoding (IDLE/SEND/WAIT/DONE)
//   - ceil_div    : integer ceiling divide, used for bytes-per-word
//   - byte_loc_t  : location of one stream byte inside the snapshot
//   - map_byte    : stream byte index -> (word, point, channel, lane)
// Build option: FFT_SER_CHECKSUM_EN is consumed by fft_result_serializer.
package fft_ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // word  : index into the stream of words (re only, or re/im interleaved)
    // point : FFT point the word belongs to
    // lane  : physical byte lane inside the (sign-extended) word
    // is_im : word comes from the imaginary channel
    typedef struct packed {
        int   word;
        int   point;
        int   lane;
        logic is_im;
    } byte_loc_t;

    function automatic byte_loc_t map_byte(input int idx, input int bpw,
                                           input int send_im, input int lsb_first);
        byte_loc_t loc;
        int        j;
        loc.word  = idx / bpw;
        j         = idx % bpw;
        loc.is_im = (send_im != 0) && ((loc.word % 2) == 1);
        loc.point = (send_im != 0) ? (loc.word / 2) : loc.word;
        loc.lane  = (lsb_first != 0) ? j : (bpw - 1 - j);
        return loc;
    endfunction

endpackage

// File: rtl/fft_byte_select.sv
// fft_byte_select
// Combinational NBYTES:1 byte selector over the captured FFT snapshot.
// Each word is sign-extended to a whole number of bytes, then the byte
// addressed by idx is picked according to the word/lane mapping.
// Ports:
//   re_flat  : snapshot real words, word k at [k*WORD_SIZE +: WORD_SIZE]
//   im_flat  : snapshot imaginary words, same packing (unused if SEND_IM=0)
//   idx      : stream byte index; indices >= NBYTES select 0
//   byte_out : selected byte
import fft_ser_pkg::*;

module fft_byte_select #(
    parameter int FFT_SIZE    = 16,
    parameter int WORD_SIZE   = 16,
    parameter int DATA_LENGTH = 8,
    parameter int SEND_IM     = 0,
    parameter int LSB_FIRST   = 1,
    parameter int IDX_W       = 6
) (
    input  logic [FFT_SIZE*WORD_SIZE-1:0] re_flat,
    input  logic [FFT_SIZE*WORD_SIZE-1:0] im_flat,
    input  logic [IDX_W-1:0]              idx,
    output logic [DATA_LENGTH-1:0]        byte_out
);

    localparam int BPW    = ceil_div(WORD_SIZE, DATA_LENGTH);
    localparam int EXT_W  = BPW * DATA_LENGTH;
    localparam int NWORDS = FFT_SIZE * (1 + SEND_IM);
    localparam int NBYTES = NWORDS * BPW;

    logic [EXT_W-1:0]       ext_word [NWORDS];
    logic [DATA_LENGTH-1:0] byte_tbl [NBYTES];

    // Word stream: re[k] only, or re[p], im[p] interleaved per point.
    for (genvar w = 0; w < NWORDS; w++) begin : g_word
        localparam byte_loc_t LOC = map_byte(w * BPW, BPW, SEND_IM, LSB_FIRST);
        logic [WORD_SIZE-1:0] raw;
        if (LOC.is_im) begin : g_im
            assign raw = im_flat[LOC.point*WORD_SIZE +: WORD_SIZE];
        end else begin : g_re
            assign raw = re_flat[LOC.point*WORD_SIZE +: WORD_SIZE];
        end
        // Words are signed: a partial top byte carries the sign.
        assign ext_word[w] = EXT_W'($signed(raw));
    end

    for (genvar c = 0; c < NBYTES; c++) begin : g_byte
        localparam byte_loc_t LOC = map_byte(c, BPW, SEND_IM, LSB_FIRST);
        assign byte_tbl[c] = ext_word[LOC.word][LOC.lane*DATA_LENGTH +: DATA_LENGTH];
    end

    if (SEND_IM == 0) begin : g_no_im
        logic unused_im;
        assign unused_im = ^im_flat;
    end

    always_comb begin
        byte_out = '0;
        for (int c = 0; c < NBYTES; c++) begin
            if (idx == IDX_W'(c)) begin
                byte_out = byte_tbl[c];
            end
        end
    end

endmodule

// File: rtl/fft_result_serializer.sv
// fft_result_serializer
// Snapshots all FFT output words on i_capture and streams them byte by
// byte to a UART transmitter.
// Build option: define FFT_SER_CHECKSUM_EN to append one XOR checksum byte
// after the payload (frame length NBYTES+1 instead of NBYTES).
// Ports:
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_capture      : one-cycle pulse, FFT results valid
//   i_re_flat      : real words, word k at [k*WORD_SIZE +: WORD_SIZE]
//   i_im_flat      : imaginary words, same packing
//   i_tx_done      : one-cycle pulse from UART, current byte finished
//   o_tx_start     : one-cycle pulse to UART, launch o_tx_byte
//   o_tx_byte      : byte to transmit (stable from start until done)
//   o_busy         : frame in progress
//   o_frame_done   : one-cycle pulse after the final byte's done
//   o_drop         : one-cycle pulse when i_capture arrives outside IDLE
//   o_dbg_state    : current FSM state (fft_ser_pkg::state_t encoding)
import fft_ser_pkg::*;

module fft_result_serializer #(
    parameter int FFT_SIZE    = 16,
    parameter int WORD_SIZE   = 16,
    parameter int DATA_LENGTH = 8,
    parameter int SEND_IM     = 0,
    parameter int LSB_FIRST   = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_capture,
    input  logic [FFT_SIZE*WORD_SIZE-1:0] i_re_flat,
    input  logic [FFT_SIZE*WORD_SIZE-1:0] i_im_flat,
    input  logic                          i_tx_done,
    output logic                          o_tx_start,
    output logic [DATA_LENGTH-1:0]        o_tx_byte,
    output logic                          o_busy,
    output logic                          o_frame_done,
    output logic                          o_drop,
    output logic [1:0]                    o_dbg_state
);

    localparam int BPW    = ceil_div(WORD_SIZE, DATA_LENGTH);
    localparam int NBYTES = FFT_SIZE * BPW * (1 + SEND_IM);
`ifdef FFT_SER_CHECKSUM_EN
    localparam int NSLOTS = NBYTES + 1;
`else
    localparam int NSLOTS = NBYTES;
`endif
    localparam int              CNT_W    = $clog2(NSLOTS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NSLOTS - 1);

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [FFT_SIZE*WORD_SIZE-1:0] snap_re_q, snap_im_q;
    logic [DATA_LENGTH-1:0]        payload_byte;
    logic [DATA_LENGTH-1:0]        cur_byte;
    logic                          capture_ok;

    assign capture_ok  = i_capture && (state_q == ST_IDLE);
    assign o_dbg_state = state_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            snap_re_q <= '0;
            snap_im_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture_ok) begin
                snap_re_q <= i_re_flat;
                snap_im_q <= i_im_flat;
            end
        end
    end

    fft_byte_select #(
        .FFT_SIZE   (FFT_SIZE),
        .WORD_SIZE  (WORD_SIZE),
        .DATA_LENGTH(DATA_LENGTH),
        .SEND_IM    (SEND_IM),
        .LSB_FIRST  (LSB_FIRST),
        .IDX_W      (CNT_W)
    ) u_byte_select (
        .re_flat (snap_re_q),
        .im_flat (snap_im_q),
        .idx     (cnt_q),
        .byte_out(payload_byte)
    );

`ifdef FFT_SER_CHECKSUM_EN
    // Running XOR of payload bytes, folded in as each byte is launched.
    logic [DATA_LENGTH-1:0] csum_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            csum_q <= '0;
        end else if (capture_ok) begin
            csum_q <= '0;
        end else if ((state_q == ST_SEND) && (cnt_q != CNT_W'(NBYTES))) begin
            csum_q <= csum_q ^ payload_byte;
        end
    end

    assign cur_byte = (cnt_q == CNT_W'(NBYTES)) ? csum_q : payload_byte;
`else
    assign cur_byte = payload_byte;
`endif

    // UART handshake: o_tx_start pulses for one cycle (SEND) with o_tx_byte
    // valid; o_tx_byte then holds until the UART returns a one-cycle
    // i_tx_done, which is honoured only in WAIT. The next start follows
    // one cycle after that done.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        o_tx_start   = 1'b0;
        o_busy       = 1'b0;
        o_frame_done = 1'b0;
        o_drop       = i_capture && (state_q != ST_IDLE);
        o_tx_byte    = '0;
        case (state_q)
            ST_IDLE: begin
                if (i_capture) begin
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                o_tx_start = 1'b1;
                o_busy     = 1'b1;
                o_tx_byte  = cur_byte;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                o_busy    = 1'b1;
                o_tx_byte = cur_byte;
                if (i_tx_done) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ST_SEND;
                    end
                end
            end
            ST_DONE: begin
                o_frame_done = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
